// File: rtl/video_pause_dim.sv
// Pause merge, long-pause RGB dimmer and 1-pixel video register stage.
// Optional PAUSE_DIM_FADE_EN: step dim_level gradually, one step per FADE_FRAMES frames.
module video_pause_dim #(
    parameter logic [31:0] DIM_CYCLES  = 32'd480_000_000,
    parameter int unsigned MAX_SHIFT   = 2,
    parameter int unsigned FADE_FRAMES = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic        pause_btn,
    input  logic        osd_open,
    input  logic        osd_pause_en,
    input  logic        hs_access,
    input  logic [11:0] rgb_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic        pause,
    output logic        user_paused,
    output logic [1:0]  dim_level,
    output logic [11:0] rgb_out,
    output logic        hblank_out,
    output logic        vblank_out,
    output logic        hs_out,
    output logic        vs_out
);

    if (MAX_SHIFT > 3 || FADE_FRAMES < 1) begin : g_param_check
        $error("video_pause_dim: MAX_SHIFT must be 0..3 and FADE_FRAMES >= 1");
    end

    localparam logic [1:0] MAX_LVL = MAX_SHIFT[1:0];

    logic        btn_q, btn_d;
    logic        user_paused_q, user_paused_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  dim_q, dim_d;
    logic [1:0]  dim_target;
    logic        frame_strobe;
    logic [11:0] rgb_q, rgb_d;
    logic        hblank_q, hblank_d;
    logic        vblank_q, vblank_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    always_comb begin
        btn_d         = pause_btn;
        user_paused_d = user_paused_q ^ (pause_btn & ~btn_q);
        if (!user_paused_q)
            timer_d = '0;
        else if (timer_q < DIM_CYCLES)
            timer_d = timer_q + 32'd1;
        else
            timer_d = timer_q;
    end

    // vblank_q is vblank_in as last sampled on ce_pix, so it doubles as the edge detector
    assign frame_strobe = ce_pix & vblank_in & ~vblank_q;
    assign dim_target   = (timer_q == DIM_CYCLES) ? MAX_LVL : 2'd0;

`ifdef PAUSE_DIM_FADE_EN
    localparam int unsigned FCW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FADE_FRAMES - 1);

    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [1:0]     tgt_q, tgt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        tgt_d  = dim_target;
        dim_d  = dim_q;
        if (dim_target != tgt_q) begin
            fcnt_d = '0;
        end else if (frame_strobe) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d = '0;
                if (dim_q < dim_target)
                    dim_d = dim_q + 2'd1;
                else if (dim_q > dim_target)
                    dim_d = dim_q - 2'd1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
            tgt_q  <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            tgt_q  <= tgt_d;
        end
    end
`else
    always_comb begin
        dim_d = frame_strobe ? dim_target : dim_q;
    end
`endif

    always_comb begin
        rgb_d    = rgb_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        if (ce_pix) begin
            if (hblank_in | vblank_in)
                rgb_d = '0;
            else
                rgb_d = {rgb_in[11:8] >> dim_q, rgb_in[7:4] >> dim_q, rgb_in[3:0] >> dim_q};
            hblank_d = hblank_in;
            vblank_d = vblank_in;
            hs_d     = hs_in;
            vs_d     = vs_in;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_q         <= 1'b0;
            user_paused_q <= 1'b0;
            timer_q       <= '0;
            dim_q         <= '0;
            rgb_q         <= '0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
        end else begin
            btn_q         <= btn_d;
            user_paused_q <= user_paused_d;
            timer_q       <= timer_d;
            dim_q         <= dim_d;
            rgb_q         <= rgb_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign pause       = hs_access | user_paused_q | (osd_open & osd_pause_en);
    assign user_paused = user_paused_q;
    assign dim_level   = dim_q;
    assign rgb_out     = rgb_q;
    assign hblank_out  = hblank_q;
    assign vblank_out  = vblank_q;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;

endmodule
